client_inj_arb: RTL and testbench

- Packet-level round-robin arbiter sharing one client injection channel between N_REQ local requesters (traffic generators, config/debug port, etc.).
- Sits between the requesters and the client output channel that feeds the shadow-register / NoC router port.
- Locks the grant for a whole packet, from the first beat until the beat flagged wlast.
- Output is a registered, backpressure-correct single-entry stage.

---
 rtl/client_inj_arb.sv | 103 ++++++++++
 tb/tb_client_inj_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/client_inj_arb.sv
// Packet-level round-robin arbiter that shares one client injection channel
// between N_REQ requesters. The grant is held for a whole packet, and the output is a registered stage that honours backpressure.
module client_inj_arb #(
  parameter int N_REQ = 2,
  parameter int D_W   = 32,
  parameter int A_W   = $clog2(N_REQ) + 1,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic [N_REQ*(A_W+D_W)-1:0]   s_wdata,
  input  logic [N_REQ-1:0]             s_wvalid,
  output logic [N_REQ-1:0]             s_wready,
  input  logic [N_REQ-1:0]             s_wlast,
  output logic [A_W+D_W-1:0]           m_axis_c_wdata,
  output logic                         m_axis_c_wvalid,
  input  logic                         m_axis_c_wready,
  output logic                         m_axis_c_wlast,
  output logic [N_REQ-1:0]             grant,
  output logic [CNT_W-1:0]             pkt_cnt
);

  localparam int BW = A_W + D_W;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   cand;
  logic            pick_found;
  logic            load_en;
  logic            in_xfer;
  logic            last_in;
  logic [BW-1:0]   owner_data;

  assign load_en    = ~m_axis_c_wvalid | m_axis_c_wready;
  assign s_wready   = (state == LOCK && ce && load_en) ? grant : '0;
  assign in_xfer    = |(s_wready & s_wvalid);
  assign owner_data = s_wdata[owner*BW +: BW];
  assign last_in    = s_wlast[owner];

  // Circular search starting one past the last packet's owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = PW'((32'(rr_ptr) + k) % N_REQ);
      if (!pick_found && s_wvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= PW'(N_REQ - 1);
      owner           <= '0;
      grant           <= '0;
      pkt_cnt         <= '0;
      m_axis_c_wvalid <= 1'b0;
      m_axis_c_wdata  <= '0;
      m_axis_c_wlast  <= 1'b0;
    end else begin
      if (m_axis_c_wvalid && m_axis_c_wready && m_axis_c_wlast)
        pkt_cnt <= pkt_cnt + CNT_W'(1);

      // The stage drains even while ce is low, because in_xfer is then zero.
      if (load_en) begin
        m_axis_c_wvalid <= in_xfer;
        if (in_xfer) begin
          m_axis_c_wdata <= owner_data;
          m_axis_c_wlast <= last_in;
        end
      end

      case (state)
        IDLE: begin
          if (ce && pick_found) begin
            grant <= N_REQ'(1) << pick_idx;
            owner <= pick_idx;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (in_xfer && last_in) begin
            state  <= IDLE;
            rr_ptr <= owner;
            grant  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_client_inj_arb.sv
// Directed self-checking bench for client_inj_arb with two requesters and a 4-bit packet counter.
module tb_client_inj_arb;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int CW = 4;
  localparam int BW = AW + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            ce;
  logic [N*BW-1:0] s_wdata;
  logic [N-1:0]    s_wvalid;
  logic [N-1:0]    s_wready;
  logic [N-1:0]    s_wlast;
  logic [BW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic [N-1:0]    grant;
  logic [CW-1:0]   pkt_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  client_inj_arb #(.N_REQ(N), .D_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .m_axis_c_wdata(m_data), .m_axis_c_wvalid(m_valid), .m_axis_c_wready(m_ready),
    .m_axis_c_wlast(m_last), .grant(grant), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] beat(input int r, input int j);
    logic [31:0] p;
    p = 32'hC0DE0000 + 32'(r * 256) + 32'(j);
    beat = {AW'(r), p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; s_wvalid = '0; s_wlast = '0; s_wdata = '0; m_ready = 1'b0;
    step(); step();
    checks++; if (grant !== 2'b00) begin $display("FAIL reset_grant: got %b expected 00", grant); errors++; end
    checks++; if (s_wready !== 2'b00) begin $display("FAIL reset_ready: got %b expected 00", s_wready); errors++; end
    checks++; if (m_valid !== 1'b0) begin $display("FAIL reset_mvalid: got %b expected 0", m_valid); errors++; end
    checks++; if (m_data !== '0) begin $display("FAIL reset_mdata: got %h expected 0", m_data); errors++; end
    checks++; if (m_last !== 1'b0) begin $display("FAIL reset_mlast: got %b expected 0", m_last); errors++; end
    checks++; if (pkt_cnt !== 4'd0) begin $display("FAIL reset_cnt: got %0d expected 0", pkt_cnt); errors++; end
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_single_packet();
    ce = 1'b1; m_ready = 1'b1;
    s_wdata[0 +: BW] = beat(0, 0); s_wlast = 2'b00; s_wvalid = 2'b01;
    step();
    checks++; if (grant !== 2'b01) begin $display("FAIL sp_grant: got %b expected 01", grant); errors++; end
    checks++; if (m_valid !== 1'b0) begin $display("FAIL sp_bubble: got %b expected 0", m_valid); errors++; end
    checks++; if (s_wready !== 2'b01) begin $display("FAIL sp_ready: got %b expected 01", s_wready); errors++; end
    for (int j = 0; j < 3; j++) begin
      step();
      checks++;
      if (m_valid !== 1'b1 || m_data !== beat(0, j) || m_last !== (j == 2)) begin
        $display("FAIL sp_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", j, m_valid, m_data, m_last, beat(0, j), (j == 2));
        errors++;
      end
      if (j < 2) begin
        s_wdata[0 +: BW] = beat(0, j + 1);
        s_wlast = (j + 1 == 2) ? 2'b01 : 2'b00;
      end
    end
    checks++; if (grant !== 2'b00) begin $display("FAIL sp_release: got %b expected 00", grant); errors++; end
    s_wvalid = 2'b00; s_wlast = 2'b00;
    step();
    exp_cnt = 1;
    checks++; if (pkt_cnt !== CW'(exp_cnt)) begin $display("FAIL sp_cnt: got %0d expected %0d", pkt_cnt, exp_cnt); errors++; end
    checks++; if (m_valid !== 1'b0) begin $display("FAIL sp_drain: got %b expected 0", m_valid); errors++; end
  endtask

  task automatic test_round_robin();
    s_wvalid = 2'b00;
    do_reset();
    ce = 1'b1; m_ready = 1'b1;
    s_wdata[0 +: BW] = beat(0, 5); s_wdata[BW +: BW] = beat(1, 5);
    s_wlast = 2'b11; s_wvalid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (grant !== ((k % 2 == 0) ? 2'b01 : 2'b10) || m_valid !== 1'b0) begin
        $display("FAIL rr_grant%0d: got g=%b v=%b expected g=%b v=0", k, grant, m_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
        errors++;
      end
      step();
      checks++;
      if (m_valid !== 1'b1 || m_data !== beat(k % 2, 5) || m_last !== 1'b1 || grant !== 2'b00) begin
        $display("FAIL rr_out%0d: got v=%b d=%h l=%b g=%b expected v=1 d=%h l=1 g=00", k, m_valid, m_data, m_last, grant, beat(k % 2, 5));
        errors++;
      end
      checks++; if (pkt_cnt !== CW'(k)) begin $display("FAIL rr_cnt%0d: got %0d expected %0d", k, pkt_cnt, k); errors++; end
    end
    s_wvalid = 2'b00; s_wlast = 2'b00;
    step();
    exp_cnt = 6;
    checks++; if (pkt_cnt !== CW'(exp_cnt)) begin $display("FAIL rr_cnt_end: got %0d expected %0d", pkt_cnt, exp_cnt); errors++; end
  endtask

  task automatic test_lock_backpressure();
    s_wvalid = 2'b00;
    do_reset();
    ce = 1'b1; m_ready = 1'b1;
    s_wdata[0 +: BW] = beat(0, 0); s_wdata[BW +: BW] = beat(1, 9);
    s_wlast = 2'b10; s_wvalid = 2'b11;
    step();
    checks++; if (grant !== 2'b01) begin $display("FAIL bp_grant: got %b expected 01", grant); errors++; end
    for (int j = 0; j < 4; j++) begin
      m_ready = 1'b1;
      #1;
      checks++; if (s_wready !== 2'b01) begin $display("FAIL bp_open%0d: got %b expected 01", j, s_wready); errors++; end
      step();
      checks++;
      if (m_valid !== 1'b1 || m_data !== beat(0, j) || m_last !== (j == 3)) begin
        $display("FAIL bp_load%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", j, m_valid, m_data, m_last, beat(0, j), (j == 3));
        errors++;
      end
      if (j < 3) begin
        s_wdata[0 +: BW] = beat(0, j + 1);
        s_wlast = (j + 1 == 3) ? 2'b11 : 2'b10;
      end
      m_ready = 1'b0;
      #1;
      checks++; if (s_wready !== 2'b00) begin $display("FAIL bp_closed%0d: got %b expected 00", j, s_wready); errors++; end
      step();
      checks++;
      if (m_valid !== 1'b1 || m_data !== beat(0, j) || m_last !== (j == 3)) begin
        $display("FAIL bp_stable%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", j, m_valid, m_data, m_last, beat(0, j), (j == 3));
        errors++;
      end
      if (j < 3) begin
        checks++; if (grant !== 2'b01) begin $display("FAIL bp_hold%0d: got %b expected 01", j, grant); errors++; end
      end
    end
    checks++; if (grant !== 2'b10) begin $display("FAIL bp_next_grant: got %b expected 10", grant); errors++; end
    m_ready = 1'b1;
    #1;
    checks++; if (s_wready !== 2'b10) begin $display("FAIL bp_req1_ready: got %b expected 10", s_wready); errors++; end
    step();
    checks++;
    if (m_data !== beat(1, 9) || m_last !== 1'b1 || pkt_cnt !== 4'd1) begin
      $display("FAIL bp_req1_out: got d=%h l=%b c=%0d expected d=%h l=1 c=1", m_data, m_last, pkt_cnt, beat(1, 9));
      errors++;
    end
    s_wvalid = 2'b00; s_wlast = 2'b00;
    step();
    exp_cnt = 2;
    checks++; if (pkt_cnt !== CW'(exp_cnt)) begin $display("FAIL bp_cnt: got %0d expected %0d", pkt_cnt, exp_cnt); errors++; end
  endtask

  task automatic test_ce_gate();
    ce = 1'b1; m_ready = 1'b1;
    s_wdata[0 +: BW] = beat(0, 0); s_wlast = 2'b00; s_wvalid = 2'b01;
    step();
    checks++; if (grant !== 2'b01) begin $display("FAIL ce_grant: got %b expected 01", grant); errors++; end
    step();
    s_wdata[0 +: BW] = beat(0, 1);
    step();
    checks++; if (m_data !== beat(0, 1) || m_valid !== 1'b1) begin $display("FAIL ce_pre: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, beat(0, 1)); errors++; end
    s_wdata[0 +: BW] = beat(0, 2);
    ce = 1'b0;
    #1;
    checks++; if (s_wready !== 2'b00) begin $display("FAIL ce_ready_low: got %b expected 00", s_wready); errors++; end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (m_valid !== 1'b0 || grant !== 2'b01 || pkt_cnt !== CW'(exp_cnt)) begin
        $display("FAIL ce_off%0d: got v=%b g=%b c=%0d expected v=0 g=01 c=%0d", c, m_valid, grant, pkt_cnt, exp_cnt);
        errors++;
      end
    end
    ce = 1'b1;
    #1;
    checks++; if (s_wready !== 2'b01) begin $display("FAIL ce_ready_back: got %b expected 01", s_wready); errors++; end
    step();
    checks++; if (m_data !== beat(0, 2) || m_valid !== 1'b1) begin $display("FAIL ce_resume: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, beat(0, 2)); errors++; end
    s_wdata[0 +: BW] = beat(0, 3); s_wlast = 2'b01;
    step();
    checks++; if (m_data !== beat(0, 3) || m_last !== 1'b1) begin $display("FAIL ce_last: got d=%h l=%b expected d=%h l=1", m_data, m_last, beat(0, 3)); errors++; end
    s_wvalid = 2'b00; s_wlast = 2'b00;
    step();
    exp_cnt = 3;
    checks++; if (pkt_cnt !== CW'(exp_cnt)) begin $display("FAIL ce_cnt: got %0d expected %0d", pkt_cnt, exp_cnt); errors++; end
  endtask

  task automatic test_reset_mid();
    ce = 1'b1; m_ready = 1'b1;
    s_wdata[BW +: BW] = beat(1, 0); s_wlast = 2'b00; s_wvalid = 2'b10;
    step();
    checks++; if (grant !== 2'b10) begin $display("FAIL rm_grant: got %b expected 10", grant); errors++; end
    step();
    s_wdata[BW +: BW] = beat(1, 1);
    step();
    checks++; if (m_data !== beat(1, 1)) begin $display("FAIL rm_pre: got %h expected %h", m_data, beat(1, 1)); errors++; end
    rst = 1'b1;
    step();
    checks++;
    if (m_valid !== 1'b0 || grant !== 2'b00 || pkt_cnt !== 4'd0 || s_wready !== 2'b00 || m_data !== '0) begin
      $display("FAIL rm_reset: got v=%b g=%b c=%0d r=%b d=%h expected all zero", m_valid, grant, pkt_cnt, s_wready, m_data);
      errors++;
    end
    rst = 1'b0;
    exp_cnt = 0;
    s_wdata[0 +: BW] = beat(0, 7); s_wlast = 2'b11; s_wvalid = 2'b11;
    step();
    checks++; if (grant !== 2'b01) begin $display("FAIL rm_first_pick: got %b expected 01", grant); errors++; end
    step();
    checks++; if (m_data !== beat(0, 7) || m_valid !== 1'b1) begin $display("FAIL rm_out: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, beat(0, 7)); errors++; end
    s_wvalid = 2'b00; s_wlast = 2'b00;
    step();
    exp_cnt = 1;
    checks++; if (pkt_cnt !== CW'(exp_cnt)) begin $display("FAIL rm_cnt: got %0d expected %0d", pkt_cnt, exp_cnt); errors++; end
  endtask

  task automatic test_wrap();
    s_wvalid = 2'b00;
    do_reset();
    ce = 1'b1; m_ready = 1'b1;
    s_wdata[0 +: BW] = beat(0, 3); s_wlast = 2'b01; s_wvalid = 2'b01;
    for (int k = 0; k < 17; k++) begin
      step();
      step();
      if (k == 15) begin
        checks++; if (pkt_cnt !== 4'd15) begin $display("FAIL wrap_15: got %0d expected 15", pkt_cnt); errors++; end
      end
    end
    s_wvalid = 2'b00; s_wlast = 2'b00;
    step();
    checks++; if (pkt_cnt !== 4'd1) begin $display("FAIL wrap_cnt: got %0d expected 1", pkt_cnt); errors++; end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_lock_backpressure();
    test_ce_gate();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
